// File: rtl/vid_pkg.sv
// Shared bus constants and state encoding for the video fetch path.
// Imported by the scheduler and its address generator.
package vid_pkg;
  localparam logic [2:0] CMD_RD    = 3'b010;
  localparam logic [2:0] CMD_RDATA = 3'b011;
  localparam logic [2:0] CMD_WR    = 3'b100;
  localparam logic [2:0] CMD_WRRSP = 3'b101;

  localparam logic [1:0] LEN_4   = 2'b10;
  localparam logic [1:0] BID_REQ = 2'b11;

  localparam logic [31:0] BURST_BYTES = 32'd16;
  localparam logic [31:0] PIX_MASK    = 32'h00FF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_NEXT,
    ST_ABORT
  } state_t;
endpackage

// File: rtl/vid_fetch_addr_gen.sv
// Frame geometry shadow registers plus line/burst position tracking.
// load captures a new frame; step advances one burst.
module vid_fetch_addr_gen
  import vid_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] base_addr,
  input  logic [31:0] lineinc,
  input  logic [12:0] hsize,
  input  logic [12:0] vsize,
  input  logic [1:0]  beat,
  output logic [31:0] burst_addr,
  output logic        last_burst,
  output logic        last_line,
  output logic        pix_valid
);
  logic [31:0] line_addr;
  logic [31:0] inc_s;
  logic [12:0] hsize_s;
  logic [12:0] vsize_s;
  logic [12:0] line_cnt;
  logic [13:0] burst_cnt;
  logic [13:0] nbursts;
  logic [15:0] pix_idx;

  assign nbursts    = ({1'b0, hsize_s} + 14'd3) >> 2;
  assign last_burst = burst_cnt == nbursts - 14'd1;
  assign last_line  = line_cnt == vsize_s - 13'd1;
  assign pix_idx    = {burst_cnt, 2'b00} + {14'd0, beat};
  assign pix_valid  = pix_idx < {3'd0, hsize_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      line_addr  <= '0;
      burst_addr <= '0;
      inc_s      <= '0;
      hsize_s    <= '0;
      vsize_s    <= '0;
      line_cnt   <= '0;
      burst_cnt  <= '0;
    end else if (load) begin
      inc_s      <= lineinc;
      hsize_s    <= hsize;
      vsize_s    <= vsize;
      line_addr  <= base_addr;
      burst_addr <= base_addr;
      line_cnt   <= '0;
      burst_cnt  <= '0;
    end else if (step) begin
      if (!last_burst) begin
        burst_cnt  <= burst_cnt + 14'd1;
        burst_addr <= burst_addr + BURST_BYTES;
      end else begin
        burst_cnt  <= '0;
        line_cnt   <= line_cnt + 13'd1;
        line_addr  <= line_addr + inc_s;
        burst_addr <= line_addr + inc_s;
      end
    end
  end
endmodule

// File: rtl/vid_fetch_sched.sv
// Frame-buffer fetch scheduler: paces 4-word read bursts against
// pixel FIFO space and pushes the returned RGB words.
module vid_fetch_sched
  import vid_pkg::*;
#(
  parameter int         FIFO_DEPTH = 64,
  parameter logic [3:0] TARGET_ID  = 4'h1,
  parameter int         TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          frame_start,
  input  logic [31:0]                   base_addr,
  input  logic [31:0]                   lineinc,
  input  logic [12:0]                   hsize,
  input  logic [12:0]                   vsize,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          ackin,
  input  logic                          selin,
  input  logic [2:0]                    cmdin,
  input  logic [31:0]                   addrdatain,
  output logic [1:0]                    reqout,
  output logic [3:0]                    reqtar,
  output logic [2:0]                    cmdout,
  output logic [1:0]                    lenout,
  output logic [31:0]                   addrdataout,
  output logic                          fifo_wr,
  output logic [31:0]                   fifo_wdata,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          err_timeout,
  output logic                          frame_overrun
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LVL_OK = LW'(FIFO_DEPTH - 4);
  localparam logic [TW-1:0] TMO    = TW'(TIMEOUT);

  state_t          state;
  logic [TW-1:0]   wait_cnt;
  logic [1:0]      beat;
  logic            pend;
  logic [31:0]     burst_addr;
  logic            last_burst;
  logic            last_line;
  logic            pix_valid;
  logic            load;
  logic            step;
  logic            is_beat;
  logic            zero_in;
  logic            last;
  logic            restart;
  logic            absorb;

  assign is_beat = selin && cmdin == CMD_RDATA;
  assign zero_in = hsize == '0 || vsize == '0;
  assign last    = last_burst && last_line;
  assign restart = en && (pend || frame_start);
  // A start landing on the final NEXT simply chains frames.
  assign absorb  = state == ST_NEXT && en && !pend && last;

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      ST_IDLE, ST_ABORT: load = frame_start && en;
      ST_CHECK:          load = restart;
      ST_NEXT: begin
        load = restart;
        step = en && !restart && !last;
      end
      default: ;
    endcase
  end

  vid_fetch_addr_gen u_addr (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .base_addr  (base_addr),
    .lineinc    (lineinc),
    .hsize      (hsize),
    .vsize      (vsize),
    .beat       (beat),
    .burst_addr (burst_addr),
    .last_burst (last_burst),
    .last_line  (last_line),
    .pix_valid  (pix_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      beat          <= '0;
      pend          <= 1'b0;
      reqout        <= '0;
      reqtar        <= '0;
      cmdout        <= '0;
      lenout        <= '0;
      addrdataout   <= '0;
      fifo_wr       <= 1'b0;
      fifo_wdata    <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      err_timeout   <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      fifo_wr    <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start && busy) begin
        pend <= 1'b1;
        if (!absorb) frame_overrun <= 1'b1;
      end
      unique case (state)
        ST_IDLE, ST_ABORT: begin
          state <= ST_IDLE;
          if (frame_start && en) begin
            if (zero_in) begin
              frame_done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (!en) begin
            busy  <= 1'b0;
            pend  <= 1'b0;
            state <= ST_IDLE;
          end else if (restart) begin
            pend <= 1'b0;
            if (zero_in) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end
          end else if (fifo_level <= LVL_OK) begin
            reqout   <= BID_REQ;
            reqtar   <= TARGET_ID;
            wait_cnt <= '0;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!en || ackin || wait_cnt == TMO) begin
            reqout <= '0;
            reqtar <= '0;
          end
          if (!en) begin
            busy  <= 1'b0;
            pend  <= 1'b0;
            state <= ST_IDLE;
          end else if (ackin) begin
            cmdout      <= CMD_RD;
            lenout      <= LEN_4;
            addrdataout <= burst_addr;
            state       <= ST_ADDR;
          end else if (wait_cnt == TMO) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            pend        <= 1'b0;
            state       <= ST_ABORT;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_ADDR: begin
          cmdout      <= '0;
          lenout      <= '0;
          addrdataout <= '0;
          beat        <= '0;
          wait_cnt    <= '0;
          state       <= ST_DATA;
        end
        ST_DATA: begin
          if (is_beat) begin
            fifo_wdata <= addrdatain & PIX_MASK;
            fifo_wr    <= pix_valid;
            wait_cnt   <= '0;
            beat       <= beat + 2'd1;
            if (beat == 2'd3) state <= ST_NEXT;
          end else if (wait_cnt == TMO) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            pend        <= 1'b0;
            state       <= ST_ABORT;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_NEXT: begin
          pend <= 1'b0;
          if (!en) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (restart) begin
            if (!pend && last) frame_done <= 1'b1;
            if (zero_in) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              state <= ST_CHECK;
            end
          end else if (last) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            state <= ST_CHECK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vid_fetch_sched.sv
// Bench for vid_fetch_sched: bus responder plus a frame-level model
// of expected burst addresses and pushed pixels.
module tb_vid_fetch_sched;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset, en, frame_start;
  logic [31:0] base_addr, lineinc;
  logic [12:0] hsize, vsize;
  logic [6:0]  fifo_level;
  logic        ackin, selin;
  logic [2:0]  cmdin;
  logic [31:0] addrdatain;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic        fifo_wr;
  logic [31:0] fifo_wdata;
  logic        busy, frame_done, err_timeout, frame_overrun;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int sent_rd = 0;
  logic [31:0] got_addr[$], got_px[$], sent[$], exp_addr[$], exp_px[$];

  vid_fetch_sched #(
    .FIFO_DEPTH (64),
    .TARGET_ID  (4'h1),
    .TIMEOUT    (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .frame_start   (frame_start),
    .base_addr     (base_addr),
    .lineinc       (lineinc),
    .hsize         (hsize),
    .vsize         (vsize),
    .fifo_level    (fifo_level),
    .ackin         (ackin),
    .selin         (selin),
    .cmdin         (cmdin),
    .addrdatain    (addrdatain),
    .reqout        (reqout),
    .reqtar        (reqtar),
    .cmdout        (cmdout),
    .lenout        (lenout),
    .addrdataout   (addrdataout),
    .fifo_wr       (fifo_wr),
    .fifo_wdata    (fifo_wdata),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_timeout   (err_timeout),
    .frame_overrun (frame_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_wr) got_px.push_back(fifo_wdata);
      if (cmdout == 3'b010) got_addr.push_back(addrdataout);
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    got_addr.delete(); got_px.delete(); sent.delete();
    exp_addr.delete(); exp_px.delete();
    sent_rd = 0;
    done_cnt = 0;
  endtask

  // Expected traffic for the first nlim bursts of a frame, in raster order.
  function automatic void model(input logic [31:0] b, i, input int h, v, nlim);
    int nb = (h + 3) / 4;
    int k = 0;
    for (int l = 0; l < v; l++)
      for (int j = 0; j < nb; j++)
        if (k < nlim) begin
          exp_addr.push_back(b + 32'(l) * i + 32'(16 * j));
          for (int w = 0; w < 4; w++) begin
            if (4 * j + w < h) exp_px.push_back(sent[sent_rd] & 32'h00FF_FFFF);
            sent_rd++;
          end
          k++;
        end
  endfunction

  task automatic start_frame(input logic [31:0] b, i, input logic [12:0] h, v);
    base_addr = b; lineinc = i; hsize = h; vsize = v;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int w = 0; w < 30 && done_cnt < target; w++) tick;
  endtask

  // fs_mode 1: frame_start with the 3rd beat; 2: frame_start right after the 4th.
  task automatic serve_burst(input int ack_dly, gap, fs_mode,
                             input logic [31:0] nb, ni, input logic [12:0] nh, nv);
    for (int w = 0; w < 100 && reqout !== 2'b11; w++) tick;
    n_chk++;
    if (reqout !== 2'b11 || reqtar !== 4'h1) begin
      n_fail++;
      $display("FAIL bid: reqout=%b reqtar=%h want 11/1", reqout, reqtar);
    end
    repeat (ack_dly) tick;
    ackin = 1'b1;
    tick;
    ackin = 1'b0;
    n_chk++;
    if (cmdout !== 3'b010 || lenout !== 2'b10) begin
      n_fail++;
      $display("FAIL cmd: cmdout=%b lenout=%b want 010/10", cmdout, lenout);
    end
    tick;
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(gap, 0)) begin
        selin = 1'b1; cmdin = 3'b101; addrdatain = $urandom;
        tick;
      end
      selin = 1'b1; cmdin = 3'b011;
      addrdatain = $urandom | 32'h8000_0000;
      sent.push_back(addrdatain);
      if (fs_mode == 1 && b == 2) begin
        base_addr = nb; lineinc = ni; hsize = nh; vsize = nv;
        frame_start = 1'b1;
      end
      tick;
      selin = 1'b0; cmdin = 3'b000; frame_start = 1'b0;
    end
    if (fs_mode == 2) begin
      base_addr = nb; lineinc = ni; hsize = nh; vsize = nv;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    n_chk++;
    if ({reqout, reqtar, cmdout, lenout, addrdataout, fifo_wr, fifo_wdata,
         busy, frame_done, err_timeout, frame_overrun} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b reqout=%b cmdout=%b want all 0", busy, reqout, cmdout);
    end
    reset = 1'b0;
    tick;
    n_chk++;
    if (busy !== 1'b0 || reqout !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b reqout=%b want 0/00", busy, reqout);
    end
  endtask

  task automatic test_two_lines;
    clear;
    start_frame(32'h1000, 32'h100, 13'd8, 13'd2);
    tick;
    n_chk++;
    if (reqout !== 2'b11) begin
      n_fail++;
      $display("FAIL start_latency: reqout=%b want 11 two cycles after frame_start", reqout);
    end
    repeat (4) serve_burst(3, 0, 0, 0, 0, 0, 0);
    model(32'h1000, 32'h100, 8, 2, 4);
    wait_done(1);
    tick;
    n_chk++;
    if (got_addr.size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL two_lines addr count: got %0d want %0d", got_addr.size(), exp_addr.size());
    end
    foreach (exp_addr[k]) if (k < got_addr.size()) begin
      n_chk++;
      if (got_addr[k] !== exp_addr[k]) begin
        n_fail++;
        $display("FAIL two_lines addr[%0d]: got %h want %h", k, got_addr[k], exp_addr[k]);
      end
    end
    n_chk++;
    if (got_px != exp_px) begin
      n_fail++;
      $display("FAIL two_lines pixels: got %0d words want %0d", got_px.size(), exp_px.size());
    end
    n_chk++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL two_lines done: frame_done count %0d busy %b want 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_partial;
    clear;
    start_frame(32'h1000, 32'h0, 13'd5, 13'd1);
    repeat (2) serve_burst(1, 1, 0, 0, 0, 0, 0);
    model(32'h1000, 32'h0, 5, 1, 2);
    wait_done(1);
    n_chk++;
    if (got_addr != exp_addr) begin
      n_fail++;
      $display("FAIL partial addrs: got %0d bursts (first %h) want 2 at 1000/1010", got_addr.size(), got_addr.size() > 0 ? got_addr[0] : 32'hx);
    end
    n_chk++;
    if (got_px.size() != 5) begin
      n_fail++;
      $display("FAIL partial wr count: got %0d want 5", got_px.size());
    end
    foreach (exp_px[k]) if (k < got_px.size()) begin
      n_chk++;
      if (got_px[k] !== exp_px[k]) begin
        n_fail++;
        $display("FAIL partial px[%0d]: got %h want %h", k, got_px[k], exp_px[k]);
      end
    end
    n_chk++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL partial done: count %0d want 1", done_cnt);
    end
  endtask

  task automatic test_fifo_gate;
    bit seen = 0;
    clear;
    fifo_level = 7'd61;
    start_frame(32'h9000, 32'h0, 13'd4, 13'd1);
    repeat (10) begin
      if (reqout !== 2'b00) seen = 1;
      tick;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL fifo_hold: reqout=11 seen with level 61, want 00");
    end
    fifo_level = 7'd60;
    tick;
    n_chk++;
    if (reqout !== 2'b11) begin
      n_fail++;
      $display("FAIL fifo_release: reqout=%b want 11", reqout);
    end
    serve_burst(0, 0, 0, 0, 0, 0, 0);
    model(32'h9000, 32'h0, 4, 1, 1);
    wait_done(1);
    fifo_level = 7'd0;
    n_chk++;
    if (got_addr != exp_addr || got_px != exp_px || done_cnt != 1) begin
      n_fail++;
      $display("FAIL fifo_frame: bursts %0d px %0d done %0d want 1/4/1", got_addr.size(), got_px.size(), done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    clear;
    start_frame(32'h6000, 32'h0, 13'd4, 13'd1);
    serve_burst(2, 0, 2, 32'h7000, 32'h0, 13'd4, 13'd1);
    n_chk++;
    if ({frame_done, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_chain: frame_done=%b busy=%b want 1/1", frame_done, busy);
    end
    serve_burst(0, 0, 0, 0, 0, 0, 0);
    model(32'h6000, 32'h0, 4, 1, 1);
    model(32'h7000, 32'h0, 4, 1, 1);
    wait_done(2);
    n_chk++;
    if (got_addr != exp_addr || got_px != exp_px) begin
      n_fail++;
      $display("FAIL b2b_traffic: bursts %0d px %0d want 2/8", got_addr.size(), got_px.size());
    end
    n_chk++;
    if (done_cnt != 2 || frame_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_flags: done %0d overrun %b want 2/0", done_cnt, frame_overrun);
    end
  endtask

  task automatic test_random;
    clear;
    for (int f = 0; f < 6; f++) begin
      logic [31:0] b, i;
      int h, v, nb;
      h = $urandom_range(1, 20);
      v = $urandom_range(1, 3);
      nb = (h + 3) / 4;
      b = (f == 2) ? 32'hFFFF_FFE8 : $urandom;
      i = $urandom;
      start_frame(b, i, 13'(h), 13'(v));
      base_addr = $urandom; lineinc = $urandom;
      hsize = 13'($urandom_range(0, 40)); vsize = 13'($urandom_range(0, 9));
      for (int k = 0; k < nb * v; k++) begin
        fifo_level = 7'($urandom_range(0, 60));
        serve_burst($urandom_range(0, 4), 2, 0, 0, 0, 0, 0);
      end
      model(b, i, h, v, nb * v);
      wait_done(f + 1);
    end
    fifo_level = 7'd0;
    n_chk++;
    if (got_addr.size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL random addr count: got %0d want %0d", got_addr.size(), exp_addr.size());
    end
    foreach (exp_addr[k]) if (k < got_addr.size()) begin
      n_chk++;
      if (got_addr[k] !== exp_addr[k]) begin
        n_fail++;
        $display("FAIL random addr[%0d]: got %h want %h", k, got_addr[k], exp_addr[k]);
      end
    end
    n_chk++;
    if (got_px.size() != exp_px.size()) begin
      n_fail++;
      $display("FAIL random px count: got %0d want %0d", got_px.size(), exp_px.size());
    end
    foreach (exp_px[k]) if (k < got_px.size()) begin
      n_chk++;
      if (got_px[k] !== exp_px[k]) begin
        n_fail++;
        $display("FAIL random px[%0d]: got %h want %h", k, got_px[k], exp_px[k]);
      end
    end
    n_chk++;
    if (done_cnt != 6 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL random done: count %0d err %b want 6/0", done_cnt, err_timeout);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    clear;
    start_frame(32'h4000, 32'h100, 13'd4, 13'd1);
    for (int w = 0; w < 20 && reqout !== 2'b11; w++) tick;
    while (err_timeout !== 1'b1 && n < TMO + 20) begin
      tick;
      n++;
    end
    n_chk++;
    if (n != TMO + 1) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d want %0d", n, TMO + 1);
    end
    n_chk++;
    if (busy !== 1'b0 || reqout !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_state: busy=%b reqout=%b want 0/00", busy, reqout);
    end
    repeat (3) tick;
    clear;
    start_frame(32'h5000, 32'h0, 13'd4, 13'd1);
    serve_burst(1, 0, 0, 0, 0, 0, 0);
    model(32'h5000, 32'h0, 4, 1, 1);
    wait_done(1);
    n_chk++;
    if (got_addr != exp_addr || got_px != exp_px || done_cnt != 1 || err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_recover: bursts %0d px %0d done %0d err %b want 1/4/1/1", got_addr.size(), got_px.size(), done_cnt, err_timeout);
    end
  endtask

  task automatic test_overrun;
    clear;
    start_frame(32'h2000, 32'h40, 13'd8, 13'd4);
    serve_burst(0, 0, 0, 0, 0, 0, 0);
    serve_burst(1, 0, 1, 32'h8000, 32'h10, 13'd4, 13'd1);
    n_chk++;
    if (frame_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_flag: got %b want 1", frame_overrun);
    end
    serve_burst(0, 0, 0, 0, 0, 0, 0);
    model(32'h2000, 32'h40, 8, 4, 2);
    model(32'h8000, 32'h10, 4, 1, 1);
    wait_done(1);
    repeat (5) tick;
    n_chk++;
    if (got_addr.size() != 3 || got_addr[2] !== 32'h8000) begin
      n_fail++;
      $display("FAIL overrun_restart: %0d bursts, last %h want 3 ending 8000", got_addr.size(), got_addr.size() > 0 ? got_addr[got_addr.size() - 1] : 32'hx);
    end
    n_chk++;
    if (got_addr != exp_addr || got_px != exp_px) begin
      n_fail++;
      $display("FAIL overrun_traffic: px %0d want %0d", got_px.size(), exp_px.size());
    end
    n_chk++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_done: count %0d busy %b want 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid;
    clear;
    start_frame(32'hA000, 32'h0, 13'd8, 13'd1);
    for (int w = 0; w < 20 && reqout !== 2'b11; w++) tick;
    ackin = 1'b1;
    tick;
    ackin = 1'b0;
    tick;
    for (int b = 0; b < 2; b++) begin
      selin = 1'b1; cmdin = 3'b011; addrdatain = $urandom;
      tick;
    end
    addrdatain = $urandom;
    reset = 1'b1;
    tick;
    selin = 1'b0; cmdin = 3'b000;
    n_chk++;
    if ({reqout, reqtar, cmdout, lenout, addrdataout, fifo_wr, fifo_wdata,
         busy, frame_done, err_timeout, frame_overrun} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b fifo_wr=%b err=%b ovr=%b want all 0", busy, fifo_wr, err_timeout, frame_overrun);
    end
    reset = 1'b0;
    repeat (3) tick;
    n_chk++;
    if (busy !== 1'b0 || reqout !== 2'b00 || cmdout !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_idle: busy=%b reqout=%b cmdout=%b want 0", busy, reqout, cmdout);
    end
  endtask

  task automatic test_zero;
    bit seen = 0;
    clear;
    start_frame(32'hB000, 32'h10, 13'd0, 13'd5);
    n_chk++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_h_done: frame_done=%b busy=%b want 1/0", frame_done, busy);
    end
    repeat (8) begin
      if (reqout !== 2'b00) seen = 1;
      tick;
    end
    start_frame(32'hB000, 32'h10, 13'd4, 13'd0);
    repeat (8) begin
      if (reqout !== 2'b00) seen = 1;
      tick;
    end
    n_chk++;
    if (seen || done_cnt != 2 || got_addr.size() != 0) begin
      n_fail++;
      $display("FAIL zero_traffic: bid %0d done %0d bursts %0d want 0/2/0", seen, done_cnt, got_addr.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b1; frame_start = 1'b0;
    base_addr = '0; lineinc = '0; hsize = '0; vsize = '0;
    fifo_level = '0; ackin = 1'b0; selin = 1'b0; cmdin = '0; addrdatain = '0;
    test_reset;
    test_two_lines;
    test_partial;
    test_fifo_gate;
    test_back_to_back;
    test_random;
    test_timeout;
    test_overrun;
    test_reset_mid;
    test_zero;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
